// File: rtl/logic_cluster_pkg.sv
// Shared types and constants for the reconfigurable logic cluster.
// Holds the loader state encoding and the per-cell config layout.
package logic_cluster_pkg;

  typedef enum logic [1:0] {
    UNCONF = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  localparam int CELL_CFG_BITS = 19;

  localparam int LUT_LSB  = 0;
  localparam int QDS_BIT  = 16;
  localparam int EN_BIT   = 17;
  localparam int INIT_BIT = 18;

  // Field order mirrors the bit layout, MSB first.
  typedef struct packed {
    logic        init;
    logic        en_use;
    logic        qds;
    logic [15:0] lut;
  } cell_cfg_t;

  function automatic int nwords(input int num_cells, input int cfg_w);
    return (num_cells * CELL_CFG_BITS + cfg_w - 1) / cfg_w;
  endfunction

endpackage

// File: rtl/logic_cluster_cell.sv
// One logic cell: LUT4 from the live config plus a D flip-flop
// with data select, enable, synchronous set and load-on-swap.
module logic_cluster_cell
  import logic_cluster_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  cell_cfg_t cfg,
  input  logic      swap,
  input  logic      new_init,
  input  logic      active,
  input  logic [3:0] lut_in,
  input  logic      qdi,
  input  logic      qen,
  input  logic      qst,
  output logic      tz,
  output logic      qz
);

  logic lut_o;
  logic d;
  logic en;
  logic q;

  assign lut_o = cfg.lut[lut_in];
  assign tz    = active & lut_o;
  assign d     = cfg.qds ? qdi : lut_o;
  assign en    = !cfg.en_use || qen;
  assign qz    = q;

  // Swap takes INIT from the incoming config, not the live one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (swap) begin
      q <= new_init;
    end else if (!active) begin
      q <= 1'b0;
    end else if (qst) begin
      q <= 1'b1;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/logic_cluster_cfg.sv
// Logic cluster with a word-wide config loader into a shadow buffer
// that is swapped atomically into the live configuration.
module logic_cluster_cfg
  import logic_cluster_pkg::*;
#(
  parameter int NUM_CELLS = 8,
  parameter int CFG_W     = 8
) (
  input  logic                   QCK,
  input  logic                   QRT,
  input  logic                   cfg_start,
  input  logic [CFG_W-1:0]       cfg_data,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  output logic                   cfg_done,
  output logic                   active,
  input  logic [4*NUM_CELLS-1:0] lut_in,
  input  logic [NUM_CELLS-1:0]   qdi,
  input  logic [NUM_CELLS-1:0]   qen,
  input  logic [NUM_CELLS-1:0]   qst,
  output logic [NUM_CELLS-1:0]   tz,
  output logic [NUM_CELLS-1:0]   qz
);

  localparam int TOTAL  = NUM_CELLS * CELL_CFG_BITS;
  localparam int NWORDS = nwords(NUM_CELLS, CFG_W);
  localparam int BUF_W  = NWORDS * CFG_W;
  localparam int CNT_W  = $clog2(NWORDS + 1);

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [BUF_W-1:0] shadow;
  logic [BUF_W-1:0] shadow_nxt;
  logic [TOTAL-1:0] live;
  logic             accept;
  logic             swap;

  assign cfg_ready = (state == LOAD);
  // A word coinciding with cfg_start is dropped.
  assign accept    = cfg_valid && cfg_ready && !cfg_start;
  assign swap      = accept && (cnt == LAST_WORD);

  always_comb begin
    shadow_nxt = shadow;
    if (accept) begin
      shadow_nxt[int'(cnt) * CFG_W +: CFG_W] = cfg_data;
    end
  end

  always_ff @(posedge QCK or negedge QRT) begin
    if (!QRT) begin
      state    <= UNCONF;
      cnt      <= '0;
      shadow   <= '0;
      live     <= '0;
      active   <= 1'b0;
      cfg_done <= 1'b0;
    end else begin
      shadow   <= shadow_nxt;
      cfg_done <= swap;
      if (swap) begin
        live <= shadow_nxt[TOTAL-1:0];
      end
      if (cfg_start) begin
        state <= LOAD;
        cnt   <= '0;
      end else if (swap) begin
        state  <= ACTIVE;
        active <= 1'b1;
      end else if (accept) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
    logic_cluster_cell u_cell (
      .clk      (QCK),
      .rst_n    (QRT),
      .cfg      (cell_cfg_t'(live[i*CELL_CFG_BITS +: CELL_CFG_BITS])),
      .swap     (swap),
      .new_init (shadow_nxt[i*CELL_CFG_BITS + INIT_BIT]),
      .active   (active),
      .lut_in   (lut_in[4*i +: 4]),
      .qdi      (qdi[i]),
      .qen      (qen[i]),
      .qst      (qst[i]),
      .tz       (tz[i]),
      .qz       (qz[i])
    );
  end

endmodule

// File: tb/tb_logic_cluster_cfg.sv
// Directed bench for logic_cluster_cfg with a bit-level reference
// model compared every cycle plus hand-computed spot checks.
module tb_logic_cluster_cfg;
  import logic_cluster_pkg::*;

  localparam int N     = 8;
  localparam int W     = 8;
  localparam int TOTAL = N * 19;
  localparam int NW    = nwords(N, W);
  localparam int BW    = NW * W;

  logic           QCK;
  logic           QRT;
  logic           cfg_start;
  logic [W-1:0]   cfg_data;
  logic           cfg_valid;
  logic           cfg_ready;
  logic           cfg_done;
  logic           active;
  logic [4*N-1:0] lut_in;
  logic [N-1:0]   qdi;
  logic [N-1:0]   qen;
  logic [N-1:0]   qst;
  logic [N-1:0]   tz;
  logic [N-1:0]   qz;

  logic_cluster_cfg #(.NUM_CELLS(N), .CFG_W(W)) dut (
    .QCK       (QCK),
    .QRT       (QRT),
    .cfg_start (cfg_start),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .active    (active),
    .lut_in    (lut_in),
    .qdi       (qdi),
    .qen       (qen),
    .qst       (qst),
    .tz        (tz),
    .qz        (qz)
  );

  initial QCK = 1'b0;
  always #5 QCK = ~QCK;

  // Reference model: 0 = unconfigured, 1 = loading, 2 = active
  int             m_mode;
  int             m_cnt;
  logic [BW-1:0]  m_sh;
  logic [TOTAL-1:0] m_live;
  bit             m_act;
  bit             m_done;
  logic [N-1:0]   m_q;
  bit             acc;
  bit             sw;
  logic [N-1:0]   nq;

  always @(posedge QCK or negedge QRT) begin
    if (!QRT) begin
      m_mode = 0;
      m_cnt  = 0;
      m_sh   = '0;
      m_live = '0;
      m_act  = 0;
      m_done = 0;
      m_q    = '0;
    end else begin
      acc = cfg_valid && (m_mode == 1) && !cfg_start;
      sw  = 0;
      if (acc) begin
        for (int b = 0; b < W; b++) m_sh[m_cnt*W + b] = cfg_data[b];
        m_cnt = m_cnt + 1;
        sw = (m_cnt == NW);
      end
      for (int i = 0; i < N; i++) begin
        bit lut_v;
        lut_v = m_live[i*19 + int'(lut_in[4*i +: 4])];
        if (!m_act) nq[i] = 1'b0;
        else if (qst[i]) nq[i] = 1'b1;
        else if (!m_live[i*19+17] || qen[i])
          nq[i] = m_live[i*19+16] ? qdi[i] : lut_v;
        else nq[i] = m_q[i];
      end
      if (sw) begin
        m_live = m_sh[TOTAL-1:0];
        for (int i = 0; i < N; i++) nq[i] = m_live[i*19+18];
        m_act  = 1;
        m_mode = 2;
      end
      m_q    = nq;
      m_done = sw;
      if (cfg_start) begin
        m_mode = 1;
        m_cnt  = 0;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Spot expectations set by the stimulus process
  logic         pin_on = 0;
  logic [N-1:0] pin_qm, pin_qv, pin_tm, pin_tv;
  logic [2:0]   pin_cm, pin_cv;

  always @(negedge QCK) begin
    logic [N-1:0] etz;
    for (int i = 0; i < N; i++)
      etz[i] = m_act & m_live[i*19 + int'(lut_in[4*i +: 4])];
    check("cfg_ready", 32'(cfg_ready), 32'(m_mode == 1));
    check("cfg_done", 32'(cfg_done), 32'(m_done));
    check("active", 32'(active), 32'(m_act));
    check("tz", 32'(tz), 32'(etz));
    check("qz", 32'(qz), 32'(m_q));
    if (pin_on) begin
      if (pin_qm != 0) check("pin_qz", 32'(qz & pin_qm), 32'(pin_qv));
      if (pin_tm != 0) check("pin_tz", 32'(tz & pin_tm), 32'(pin_tv));
      if (pin_cm != 0)
        check("pin_ctl", 32'({active, cfg_ready, cfg_done} & pin_cm),
              32'(pin_cv));
    end
  end

  task automatic cyc();
    @(posedge QCK);
    #1;
  endtask

  // Control fields ordered {active, cfg_ready, cfg_done}
  task automatic pin(input logic [N-1:0] qm, input logic [N-1:0] qv,
                     input logic [N-1:0] tm, input logic [N-1:0] tv,
                     input logic [2:0] cm, input logic [2:0] cv);
    pin_qm = qm; pin_qv = qv;
    pin_tm = tm; pin_tv = tv;
    pin_cm = cm; pin_cv = cv;
    pin_on = 1;
    cyc();
    pin_on = 0;
  endtask

  function automatic logic [BW-1:0] img(input logic [18:0] c0,
                                        input logic [18:0] c1);
    img = '0;
    img[18:0]  = c0;
    img[37:19] = c1;
  endfunction

  task automatic load_start();
    cfg_start = 1;
    cfg_valid = 1;
    cfg_data  = 8'hA5;
    cyc();
    cfg_start = 0;
    cfg_valid = 0;
  endtask

  task automatic send(input logic [BW-1:0] im, input int k0,
                      input int k1, input bit gap);
    for (int k = k0; k < k1; k++) begin
      cfg_data  = im[k*W +: W];
      cfg_valid = 1;
      cyc();
      if (gap && k < k1 - 1) begin
        cfg_valid = 0;
        cfg_data  = 8'h3C;
        cyc();
      end
    end
    cfg_valid = 0;
  endtask

  localparam logic [18:0] C_AND = 19'h48000;
  localparam logic [18:0] C_OR  = 19'h4FFFE;
  localparam logic [18:0] C_DE  = 19'h30000;
  localparam logic [18:0] C_DE1 = 19'h70000;

  logic [BW-1:0] im1, im2, im3;

  initial begin
    QRT = 0;
    cfg_start = 0; cfg_data = '0; cfg_valid = 0;
    lut_in = '1; qdi = '0; qen = '0; qst = '0;
    im1 = img(C_AND, C_DE);
    im2 = img(C_OR, C_DE);
    im3 = img(C_OR, C_DE1);
    cyc();
    pin('1, '0, '1, '0, 3'b111, 3'b000);
    QRT = 1;
    pin('0, '0, '0, '0, 3'b010, 3'b000);

    // first load
    load_start();
    pin('0, '0, '0, '0, 3'b110, 3'b010);
    send(im1, 0, NW, 0);
    pin(8'h01, 8'h01, '0, '0, 3'b111, 3'b101);
    lut_in[3:0] = 4'hF;
    pin('0, '0, 8'h01, 8'h01, 3'b001, 3'b000);
    pin(8'h01, 8'h01, '0, '0, 3'b000, 3'b000);
    lut_in[3:0] = 4'hE;
    pin('0, '0, 8'h01, 8'h00, 3'b000, 3'b000);
    pin(8'h01, 8'h00, '0, '0, 3'b000, 3'b000);

    // enable / set on cell 1
    qdi[1] = 1; qen[1] = 0;
    cyc();
    pin(8'h02, 8'h00, '0, '0, 3'b000, 3'b000);
    qen[1] = 1;
    cyc();
    pin(8'h02, 8'h02, '0, '0, 3'b000, 3'b000);
    qdi[1] = 0;
    cyc();
    pin(8'h02, 8'h00, '0, '0, 3'b000, 3'b000);
    qst[1] = 1;
    cyc();
    pin(8'h02, 8'h02, '0, '0, 3'b000, 3'b000);
    qst[1] = 0; qen[1] = 0;

    // valid gaps, then valid ignored after swap
    load_start();
    send(im1, 0, NW, 1);
    pin('0, '0, '0, '0, 3'b101, 3'b101);
    cfg_valid = 1;
    pin('0, '0, '0, '0, 3'b011, 3'b000);
    pin('0, '0, '0, '0, 3'b011, 3'b000);
    cfg_valid = 0;

    // live reconfiguration AND4 -> OR4
    lut_in[3:0] = 4'h1;
    load_start();
    pin('0, '0, 8'h01, 8'h00, 3'b110, 3'b110);
    send(im2, 0, NW - 1, 0);
    pin('0, '0, 8'h01, 8'h00, 3'b100, 3'b100);
    send(im2, NW - 1, NW, 0);
    pin(8'h01, 8'h01, 8'h01, 8'h01, 3'b101, 3'b101);

    // restart mid-load
    load_start();
    send(im3, 0, 7, 0);
    load_start();
    send(im3, 0, 12, 0);
    pin('0, '0, '0, '0, 3'b011, 3'b010);
    send(im3, 12, NW, 0);
    pin(8'h02, 8'h02, '0, '0, 3'b011, 3'b001);

    // async reset mid-load
    load_start();
    send(im3, 0, 10, 0);
    #2 QRT = 0;
    pin('1, '0, '1, '0, 3'b111, 3'b000);
    QRT = 1;
    cfg_valid = 1;
    pin('0, '0, '0, '0, 3'b110, 3'b000);
    cfg_valid = 0;
    load_start();
    pin('0, '0, '0, '0, 3'b110, 3'b010);
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_cluster_cfg.md
Name: logic_cluster_cfg

Overview:
- Parametrised successor to the single PP3 logic cell: a cluster of NUM_CELLS cells, each a LUT4 plus a D flip-flop with data select, enable and synchronous set.
- Per-cell configuration is loaded at run time over a word-wide valid/ready port into a shadow buffer. It is swapped atomically into the live configuration, so the cluster keeps running on the old configuration while a new one loads.
- Sits below the tile wrapper as the behavioural model for the runtime-reconfigurable logic tile.

Parameters:
- NUM_CELLS, 8, number of logic cells in the cluster (1..32).
- CFG_W, 8, configuration word width in bits (1..32).
- CELL_CFG_BITS, 19, per-cell config bits. Fixed layout; exposed as a package constant, not overridable.

Ports:
- QCK, input, 1, cluster clock; all state is updated on the rising edge.
- QRT, input, 1, asynchronous active-low reset.
- cfg_start, input, 1, pulse that begins a configuration load.
- cfg_data, input, CFG_W, configuration word.
- cfg_valid, input, 1, cfg_data is valid.
- cfg_ready, output, 1, loader accepts a word this cycle.
- cfg_done, output, 1, one-cycle pulse on the swap cycle.
- active, output, 1, a live configuration is in use.
- lut_in, input, 4*NUM_CELLS, LUT inputs; cell i uses bits [4i+3:4i], with bit 4i as the LSB of the LUT index.
- qdi, input, NUM_CELLS, direct register data per cell.
- qen, input, NUM_CELLS, register enable per cell.
- qst, input, NUM_CELLS, synchronous set per cell.
- tz, output, NUM_CELLS, combinational LUT output per cell.
- qz, output, NUM_CELLS, register output per cell.

Behaviour:
- Reset: QRT low asynchronously clears the FSM to UNCONF, the word counter, the shadow and live configuration, and all cell registers.
  - Outputs during reset: cfg_ready=0, cfg_done=0, active=0, tz=0, qz=0.
- Per-cell config layout, LSB first: [15:0] LUT truth table, [16] QDS (1 = register D from qdi, 0 = from LUT), [17] EN_USE (1 = honour qen, 0 = always enabled), [18] INIT (register value loaded on swap).
- Cell i occupies bits [19i+18:19i] of a flat TOTAL = NUM_CELLS*19 bit vector.
- NWORDS = ceil(TOTAL/CFG_W). Word k fills bits [k*CFG_W +: CFG_W]. Pad bits above TOTAL in the last word are ignored.
- FSM states: UNCONF, LOAD, ACTIVE.
  - UNCONF --cfg_start--> LOAD.
  - LOAD --last word accepted--> ACTIVE.
  - ACTIVE --cfg_start--> LOAD.
  - cfg_start while in LOAD restarts the load: word counter goes to 0 and partial shadow contents are discarded (overwritten).
  - A word handshaken in the same cycle as cfg_start is dropped.
- cfg_ready=1 exactly while in LOAD. A word is accepted when cfg_valid && cfg_ready; the word counter increments, no wrap.
- Swap timing: when word NWORDS-1 is accepted, on that same edge:
  - shadow (including the final word) is copied to live;
  - every cell register loads its new INIT;
  - cfg_done pulses for the following cycle;
  - the FSM enters ACTIVE.
- Load latency: NWORDS accepted handshakes, plus 0 extra cycles to the swap edge.
- Double buffering: during LOAD that follows ACTIVE, active stays 1 and cells operate on the old live configuration. During LOAD from UNCONF, active=0.
- tz[i] = active ? LUT[lut_in[i]] : 0.
- Register priority per edge, when not in reset:
  1. swap → INIT;
  2. !active → 0;
  3. qst[i] → 1;
  4. (!EN_USE || qen[i]) → (QDS ? qdi[i] : LUT output);
  5. otherwise hold.
- qz = register value; it is 0 whenever active=0.
- Reset asserted mid-load aborts the load; the FSM returns to UNCONF.

Decomposition:
- Package logic_cluster_pkg holds:
  - state enum {UNCONF, LOAD, ACTIVE};
  - CELL_CFG_BITS=19;
  - field offsets LUT_LSB=0, QDS_BIT=16, EN_BIT=17, INIT_BIT=18;
  - function nwords(num_cells, cfg_w).
- One sub-module, logic_cluster_cell: the LUT4 mux plus register, driven by its live config slice, swap and active. Instantiated NUM_CELLS times in a generate loop.
- Loader FSM, counter and shadow/live buffers stay in the top module.

Test Plan:
- Reset and first load (N=8, CFG_W=8, NWORDS=19):
  - Stimulus: reset, then cfg_start, then 19 words, cell 0 configured LUT=16'h8000, QDS=0, EN_USE=0, INIT=1.
  - Required: cfg_done pulses once; qz[0]=1 the cycle after swap; active=1.
  - Then lut_in[3:0]=4'hF gives tz[0]=1 and next-cycle qz[0]=1; lut_in[3:0]=4'hE gives tz[0]=0 and next-cycle qz[0]=0.
- Enable and set on cell 1 (QDS=1, EN_USE=1):
  - qdi=1, qen=0 → qz holds.
  - qen=1 → qz=1 next cycle.
  - qst=1 with qen=1, qdi=0 → qz=1 (set wins).
- Valid/ready gaps:
  - cfg_valid toggled 1,0,1 across 19 words → exactly 19 accepts.
  - cfg_ready=0 after the swap; further cfg_valid ignored.
- Live reconfiguration:
  - In ACTIVE with cell 0 LUT=AND4, start a load with LUT=OR4.
  - Required: tz[0] follows AND4 until the swap edge, then OR4; active never drops.
- Restart mid-load: cfg_start after 7 words → counter back to 0; cfg_done only after 19 further words.
- Async reset mid-load: QRT low asynchronously after word 10 → immediate active=0, cfg_ready=0, tz=0, qz=0; the FSM is in UNCONF after release.
